// File: rtl/mac_share_ctrl.sv
// mac_share_ctrl
//   Round-robin controller that shares one three-sample multiply-add
//   datapath (data_out = a*b+c) between NREQ requesters.  A granted
//   requester's (a,b,c) triplet is streamed into the datapath on three
//   consecutive validi cycles.  The datapath result is checked against a
//   locally computed a*b+c and returned with an error flag.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/a/b/c       per-requester request and packed operands
//   req_ready             one-hot grant pulse
//   rsp_valid             one-hot response pulse
//   rsp_data, rsp_err     response payload, qualified by rsp_valid
//   busy                  high from the grant cycle through the response cycle
//   validi, data_in       sample stream to the datapath
//   valido, data_out      result from the datapath
module mac_share_ctrl #(
    parameter int NREQ = 2,
    parameter int DW   = 8,
    parameter int TMO  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*DW-1:0] req_c,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              validi,
    output logic [DW-1:0]     data_in,
    input  logic              valido,
    input  logic [DW-1:0]     data_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO + 1);
    localparam int PW = 2 * DW;

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, SEND_C, WAIT, RESP} state_t;

    state_t          state_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   idx_q;
    logic [DW-1:0]   a_q, b_q, c_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] req_ready_q, rsp_valid_q;
    logic [DW-1:0]   rsp_data_q, data_in_q;
    logic            rsp_err_q, busy_q, validi_q;

    logic [IW-1:0]   arb_base;
    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    int unsigned     pos;
    logic [DW-1:0]   sel_a, sel_b, sel_c;
    logic [PW-1:0]   full_res;
    logic [DW-1:0]   exp_res;

    // The state register always names the phase whose outputs are currently
    // visible.  A grant shows up while still in IDLE with req_ready_q set,
    // and the RESP cycle arbitrates so the next grant lands in the IDLE cycle
    // directly after it; RESP therefore starts its search after idx_q.
    always_comb begin
        arb_base  = (state_q == RESP) ? idx_q : last_q;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        pos       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = (32'(arb_base) + 32'd1 + k) % NREQ;
            if (!gnt_found && req_valid[IW'(pos)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(pos);
            end
        end
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IW'(i) == gnt_idx) begin
                sel_a = req_a[i*DW +: DW];
                sel_b = req_b[i*DW +: DW];
                sel_c = req_c[i*DW +: DW];
            end
        end
        full_res = PW'(a_q) * PW'(b_q) + PW'(c_q);
        exp_res  = full_res[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            validi_q    <= 1'b0;
            data_in_q   <= '0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_ready_q != '0) begin
                        state_q   <= SEND_A;
                        validi_q  <= 1'b1;
                        data_in_q <= a_q;
                    end else if (gnt_found) begin
                        req_ready_q <= NREQ'(1) << gnt_idx;
                        idx_q       <= gnt_idx;
                        a_q         <= sel_a;
                        b_q         <= sel_b;
                        c_q         <= sel_c;
                        busy_q      <= 1'b1;
                    end
                end
                SEND_A: begin
                    state_q   <= SEND_B;
                    data_in_q <= b_q;
                end
                SEND_B: begin
                    state_q   <= SEND_C;
                    data_in_q <= c_q;
                end
                SEND_C: begin
                    state_q   <= WAIT;
                    validi_q  <= 1'b0;
                    data_in_q <= '0;
                    cnt_q     <= '0;
                end
                WAIT: begin
                    if (valido) begin
                        state_q     <= RESP;
                        rsp_valid_q <= NREQ'(1) << idx_q;
                        rsp_data_q  <= data_out;
                        rsp_err_q   <= (data_out != exp_res);
                    end else if (cnt_q == CW'(TMO - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= NREQ'(1) << idx_q;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    last_q     <= idx_q;
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    if (gnt_found) begin
                        req_ready_q <= NREQ'(1) << gnt_idx;
                        idx_q       <= gnt_idx;
                        a_q         <= sel_a;
                        b_q         <= sel_b;
                        c_q         <= sel_c;
                        busy_q      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign validi    = validi_q;
    assign data_in   = data_in_q;

endmodule

// File: tb/tb_mac_share_ctrl.sv
// tb_mac_share_ctrl
//   Drives mac_share_ctrl with directed and random requests, emulates the
//   three-sample datapath (normal, silent, or off-by-one), and compares every
//   cycle against a transaction-level model of grant order, sample stream,
//   response timing and payload.
module tb_mac_share_ctrl;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int TMO  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_a = '0, req_b = '0, req_c = '0;
    logic [NREQ-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]      rsp_data, data_in;
    logic               rsp_err, busy, validi;
    logic               valido = 1'b0;
    logic [DW-1:0]      data_out = '0;

    mac_share_ctrl #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .validi(validi), .data_in(data_in),
        .valido(valido), .data_out(data_out)
    );

    // Datapath emulation: mode 0 correct, 1 never answers, 2 answers result+1.
    int         dp_mode = 0;
    logic [1:0] vcnt = '0;
    logic [7:0] d1 = '0, d2 = '0;
    always @(posedge clk) begin
        valido   <= 1'b0;
        data_out <= '0;
        if (validi) begin
            d2 <= d1;
            d1 <= data_in;
            if (vcnt == 2'd2) begin
                vcnt     <= '0;
                valido   <= (dp_mode != 1);
                data_out <= (dp_mode == 2) ? 8'(d2 * d1 + data_in + 8'd1) : 8'(d2 * d1 + data_in);
            end else begin
                vcnt <= vcnt + 2'd1;
            end
        end else begin
            vcnt <= '0;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle time %0t)", nm, got, exp, $time);
        end
    endtask

    // Requester side
    int ra[NREQ], rb[NREQ], rc[NREQ];
    int policy = 0;       // 0 drop after grant, 1 hold continuously, 2 random
    int force_mode = 0;   // -1 picks a datapath mode per transaction

    // Model state
    int  cyc = 0;
    bit  act = 0;
    int  tg, trsp, midx, mmode, ea, eb, ec;
    int  last = NREQ - 1;
    bit  free_prev = 0;
    int  gcyc[NREQ];

    typedef struct {int idx; int data; int err; int lat;} rsp_t;
    rsp_t rlog[$];
    int   gseq[$];

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int lst);
        for (int k = 1; k <= NREQ; k++)
            if (v[(lst + k) % NREQ]) return (lst + k) % NREQ;
        return -1;
    endfunction

    task automatic cycle_check(input logic rst_s, input logic [NREQ-1:0] rv_s);
        int g;
        bit exp_v, exp_r, free_now;
        int ed, ee, vi;
        if (rst_s) begin
            chk("reset_outputs", {req_ready, rsp_valid, rsp_data, rsp_err, busy, validi, data_in}, 0);
            act = 0;
            last = NREQ - 1;
            free_prev = 1;
            return;
        end
        chk("ready_without_valid", req_ready & ~req_valid, 0);
        g = (free_prev && rv_s != '0) ? rr_pick(rv_s, last) : -1;
        chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) begin gcyc[i] = cyc; gseq.push_back(i); end
        if (g >= 0) begin
            act = 1; tg = cyc; midx = g;
            ea = ra[g]; eb = rb[g]; ec = rc[g];
            mmode = (force_mode >= 0) ? force_mode :
                    (($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2)));
            dp_mode = mmode;
            trsp = (mmode == 1) ? cyc + 4 + TMO : cyc + 5;
        end
        exp_v = act && cyc >= tg + 1 && cyc <= tg + 3;
        chk("validi", validi, exp_v);
        if (exp_v)
            chk("data_in", data_in, (cyc == tg + 1) ? ea : (cyc == tg + 2) ? eb : ec);
        exp_r = act && cyc == trsp;
        chk("rsp_valid", rsp_valid, exp_r ? (1 << midx) : 0);
        if (exp_r) begin
            ed = (mmode == 1) ? 0 : (ea * eb + ec + ((mmode == 2) ? 1 : 0)) % 256;
            ee = (mmode != 0);
            chk("rsp_data", rsp_data, ed);
            chk("rsp_err", rsp_err, ee);
        end
        chk("busy", busy, act && cyc >= tg && cyc <= trsp);
        if (rsp_valid != '0) begin
            vi = 0;
            for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) vi = i;
            rlog.push_back('{vi, int'(rsp_data), int'(rsp_err), cyc - gcyc[vi]});
        end
        free_now = !act || cyc == trsp;
        if (act && cyc == trsp) begin act = 0; last = midx; end
        free_prev = free_now;
    endtask

    task automatic step();
        logic rst_s;
        logic [NREQ-1:0] rv_s;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = DW'(ra[i]);
            req_b[i*DW +: DW] = DW'(rb[i]);
            req_c[i*DW +: DW] = DW'(rc[i]);
        end
        rst_s = rst;
        rv_s  = req_valid;
        @(negedge clk);
        cyc++;
        cycle_check(rst_s, rv_s);
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && req_valid[i]) req_valid[i] = (policy == 1);
            if (policy == 2 && !req_valid[i] && $urandom_range(0, 2) == 0) begin
                ra[i] = $urandom_range(0, 255);
                rb[i] = $urandom_range(0, 255);
                rc[i] = $urandom_range(0, 255);
                req_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_rsp(input int n);
        int b = 0;
        while (rlog.size() < n && b < 300) begin step(); b++; end
        if (rlog.size() < n) chk("rsp_wait_timeout", rlog.size(), n);
    endtask

    task automatic drain();
        int b = 0;
        while ((req_valid != '0 || act) && b < 400) begin step(); b++; end
        chk("drain_timeout", {req_valid, act}, 0);
        step(); step();
    endtask

    task automatic set_req(input int i, input int a, input int b, input int c);
        ra[i] = a; rb[i] = b; rc[i] = c;
        req_valid[i] = 1'b1;
    endtask

    initial begin
        int n, gs;
        for (int i = 0; i < NREQ; i++) begin ra[i] = 0; rb[i] = 0; rc[i] = 0; gcyc[i] = 0; end

        // Reset with both requesters pending; first grant must go to 0.
        rst = 1'b1;
        set_req(0, 3, 4, 5);
        set_req(1, 20, 20, 100);
        repeat (3) step();
        rst = 1'b0;
        wait_rsp(2);
        drain();
        chk("first_grant", gseq[0], 0);
        chk("r0_idx", rlog[0].idx, 0);
        chk("r0_data", rlog[0].data, 17);
        chk("r0_err", rlog[0].err, 0);
        chk("r0_latency", rlog[0].lat, 5);
        chk("wrap_idx", rlog[1].idx, 1);
        chk("wrap_data", rlog[1].data, 244);
        chk("wrap_err", rlog[1].err, 0);

        // Continuous requests from both: strict alternation.
        gs = gseq.size();
        n = rlog.size();
        policy = 1;
        set_req(0, 1, 2, 3);
        set_req(1, 5, 6, 7);
        wait_rsp(n + 4);
        policy = 0;
        drain();
        for (int k = 0; k < 4; k++) begin
            chk("arb_grant", gseq[gs + k], k % 2);
            chk("arb_rsp_idx", rlog[n + k].idx, k % 2);
            chk("arb_rsp_data", rlog[n + k].data, (k % 2) ? 37 : 5);
        end

        // Single request, correct datapath.
        n = rlog.size();
        set_req(0, 3, 4, 5);
        wait_rsp(n + 1);
        drain();
        chk("single_data", rlog[n].data, 17);
        chk("single_latency", rlog[n].lat, 5);

        // Datapath never answers.
        force_mode = 1;
        n = rlog.size();
        set_req(0, 3, 4, 5);
        wait_rsp(n + 1);
        drain();
        chk("tmo_data", rlog[n].data, 0);
        chk("tmo_err", rlog[n].err, 1);
        chk("tmo_latency", rlog[n].lat, 4 + TMO);

        // Corrupted datapath result.
        force_mode = 2;
        n = rlog.size();
        set_req(0, 3, 4, 5);
        wait_rsp(n + 1);
        drain();
        chk("bad_data", rlog[n].data, 18);
        chk("bad_err", rlog[n].err, 1);

        // Reset during SEND_B, then re-request.
        force_mode = 0;
        n = rlog.size();
        set_req(1, 7, 9, 11);
        begin
            int b = 0;
            while (!(validi && data_in == 8'd9) && b < 50) begin step(); b++; end
            chk("reach_send_b", validi && data_in == 8'd9, 1);
        end
        rst = 1'b1;
        req_valid[1] = 1'b1;
        step();
        chk("midrst_validi", validi, 0);
        rst = 1'b0;
        wait_rsp(n + 1);
        drain();
        chk("midrst_rsp_count", rlog.size(), n + 1);
        chk("midrst_idx", rlog[n].idx, 1);
        chk("midrst_data", rlog[n].data, 74);
        chk("midrst_err", rlog[n].err, 0);

        // Random traffic with random datapath behaviour.
        force_mode = -1;
        policy = 2;
        repeat (800) step();
        policy = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
